// File: rtl/noc_pkt_pkg.sv
// Packet word layout shared by the NoC traffic generator and the sink checker.
// Word layout, MSB first: {src, dest, id[7:0], count}.
package noc_pkt_pkg;

    localparam int MAX_W     = 64;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_N     = 16;

    typedef logic [MAX_W-1:0] word_t;

    function automatic int addr_w(input int n);
        return $clog2(n);
    endfunction

    function automatic int cnt_w(input int width, input int n);
        return width - 2 * addr_w(n) - 8;
    endfunction

    localparam int DEF_A  = addr_w(DEF_N);
    localparam int DEF_CW = cnt_w(DEF_WIDTH, DEF_N);

    typedef struct packed {
        logic [DEF_A-1:0]  src;
        logic [DEF_A-1:0]  dest;
        logic [7:0]        id;
        logic [DEF_CW-1:0] cnt;
    } pkt_t;

    // Extract w bits starting at bit lsb; w is always below MAX_W for legal layouts.
    function automatic word_t field(input word_t d, input int lsb, input int w);
        word_t mask;
        mask = (word_t'(1) << w) - word_t'(1);
        return (d >> lsb) & mask;
    endfunction

    function automatic word_t get_src(input word_t d, input int width, input int a);
        return field(d, width - a, a);
    endfunction

    function automatic word_t get_dest(input word_t d, input int width, input int a);
        return field(d, width - 2 * a, a);
    endfunction

    function automatic word_t get_id(input word_t d, input int width, input int a);
        return field(d, width - 2 * a - 8, 8);
    endfunction

    function automatic word_t get_cnt(input word_t d, input int width, input int a);
        return field(d, 0, width - 2 * a - 8);
    endfunction

endpackage

// File: rtl/sink_seq_table.sv
// Per-source expected sequence count table: combinational read, write on accept.
// The write commits at the accept edge, so a back-to-back lookup from the same source sees it.
module sink_seq_table #(
    parameter int N  = 16,
    parameter int A  = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [A-1:0]  rd_addr_i,
    output logic [CW-1:0] rd_data_o,
    input  logic          wr_en_i,
    input  logic [A-1:0]  wr_addr_i,
    input  logic [CW-1:0] wr_data_i
);

    logic [CW-1:0] mem_q [N];

    // A source's first packet carries count 1, hence the reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= CW'(1);
            end
        end else if (wr_en_i && (int'(wr_addr_i) < N)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_o = CW'(1);
        if (int'(rd_addr_i) < N) begin
            rd_data_o = mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/sink_checker.sv
// NoC output-port packet sink: throttled valid/ready intake, destination check and
// per-source in-order, gap-free sequence check, with packet count and error flags.
module sink_checker
    import noc_pkt_pkg::*;
#(
    parameter int                      WIDTH        = 32,
    parameter int                      N            = 16,
    parameter int                      N_ADDR_WIDTH = $clog2(N),
    parameter logic [N_ADDR_WIDTH-1:0] NODE         = '0,
    parameter int                      READY_PERIOD = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        data_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic [31:0]             pkt_count,
    output logic                    err_seq,
    output logic                    err_dest,
    output logic                    err_sticky,
    output logic [N_ADDR_WIDTH-1:0] last_src,
    output logic [7:0]              last_id
);

    localparam int         A       = N_ADDR_WIDTH;
    localparam int         CW      = WIDTH - 2 * A - 8;
    localparam logic [7:0] TC_LAST = 8'(READY_PERIOD - 1);

    // Handshake: a word transfers on a clk edge where valid_in && ready_out. The
    // upstream holds data_in stable while valid_in is high and ready_out is low;
    // ready_out does not depend on valid_in.

    logic [7:0] tc_q, tc_d;
    logic       ready_q, ready_d;

    always_comb begin
        tc_d    = (tc_q == TC_LAST) ? 8'd0 : tc_q + 8'd1;
        ready_d = (tc_d == 8'd0);
    end

    // ready_q is cleared by rst, so it stays low for the first cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tc_q    <= 8'd0;
            ready_q <= 1'b0;
        end else begin
            tc_q    <= tc_d;
            ready_q <= ready_d;
        end
    end

    // Gating with rst drops whatever is presented during a reset cycle.
    assign ready_out = ready_q & ~rst;

    logic          accept;
    logic [A-1:0]  src;
    logic [A-1:0]  dest;
    logic [7:0]    id;
    logic [CW-1:0] cnt;
    logic [CW-1:0] exp_cnt;
    logic          src_ok;
    logic          tbl_wr;

    assign accept = valid_in && ready_out;
    assign src    = A'(get_src(word_t'(data_in), WIDTH, A));
    assign dest   = A'(get_dest(word_t'(data_in), WIDTH, A));
    assign id     = 8'(get_id(word_t'(data_in), WIDTH, A));
    assign cnt    = CW'(get_cnt(word_t'(data_in), WIDTH, A));
    assign src_ok = (int'(src) < N);
    assign tbl_wr = accept && src_ok;

    // Count+1 is written even on a mismatch so a single lost packet costs one error.
    sink_seq_table #(
        .N  (N),
        .A  (A),
        .CW (CW)
    ) u_seq_table (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_i (src),
        .rd_data_o (exp_cnt),
        .wr_en_i   (tbl_wr),
        .wr_addr_i (src),
        .wr_data_i (cnt + CW'(1))
    );

    logic [31:0]  pkt_count_q, pkt_count_d;
    logic         err_seq_q, err_seq_d;
    logic         err_dest_q, err_dest_d;
    logic         err_sticky_q, err_sticky_d;
    logic [A-1:0] last_src_q, last_src_d;
    logic [7:0]   last_id_q, last_id_d;

    always_comb begin
        pkt_count_d  = pkt_count_q;
        err_seq_d    = 1'b0;
        err_dest_d   = 1'b0;
        err_sticky_d = err_sticky_q;
        last_src_d   = last_src_q;
        last_id_d    = last_id_q;
        if (accept) begin
            pkt_count_d  = (pkt_count_q == 32'hFFFF_FFFF) ? pkt_count_q : pkt_count_q + 32'd1;
            last_src_d   = src;
            last_id_d    = id;
            // An out-of-range source is reported as a routing error, not a sequence error.
            err_dest_d   = (dest != NODE) || !src_ok;
            err_seq_d    = src_ok && (cnt != exp_cnt);
            err_sticky_d = err_sticky_q | err_dest_d | err_seq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_q  <= 32'd0;
            err_seq_q    <= 1'b0;
            err_dest_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            last_src_q   <= '0;
            last_id_q    <= 8'd0;
        end else begin
            pkt_count_q  <= pkt_count_d;
            err_seq_q    <= err_seq_d;
            err_dest_q   <= err_dest_d;
            err_sticky_q <= err_sticky_d;
            last_src_q   <= last_src_d;
            last_id_q    <= last_id_d;
        end
    end

    assign pkt_count  = pkt_count_q;
    assign err_seq    = err_seq_q;
    assign err_dest   = err_dest_q;
    assign err_sticky = err_sticky_q;
    assign last_src   = last_src_q;
    assign last_id    = last_id_q;

endmodule
